// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter merging ALU/LSU/CSR write-backs onto one registered register-file write port.
// Optional read bypass of the pending write is enabled with the RF_WB_BYPASS_EN macro.
module rf_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              req_valid,
    output logic [2:0]              req_ready,
    input  logic [3*ADDR_WIDTH-1:0] req_addr,
    input  logic [3*DATA_WIDTH-1:0] req_data,
    output logic                    rf_wen,
    output logic [ADDR_WIDTH-1:0]   rf_waddr,
    output logic [DATA_WIDTH-1:0]   rf_wdata,
    input  logic [ADDR_WIDTH-1:0]   raddr1,
    input  logic [ADDR_WIDTH-1:0]   raddr2,
    input  logic [DATA_WIDTH-1:0]   rdata1_in,
    input  logic [DATA_WIDTH-1:0]   rdata2_in,
    output logic [DATA_WIDTH-1:0]   rdata1,
    output logic [DATA_WIDTH-1:0]   rdata2,
    output logic                    busy
);

    // Handshake: a write transfers from requester i in any cycle where
    // req_valid[i] && req_ready[i]; the requester holds valid/addr/data
    // stable until then. req_ready is combinational and one-hot or zero.

    logic [1:0]            last_grant;
    logic [2:0]            grant;
    logic [1:0]            grant_idx;
    logic                  transfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Priority rotates to start just after the most recent winner.
    always_comb begin
        grant = 3'b000;
        case (last_grant)
            2'd0: begin
                if (req_valid[1])      grant = 3'b010;
                else if (req_valid[2]) grant = 3'b100;
                else if (req_valid[0]) grant = 3'b001;
            end
            2'd1: begin
                if (req_valid[2])      grant = 3'b100;
                else if (req_valid[0]) grant = 3'b001;
                else if (req_valid[1]) grant = 3'b010;
            end
            default: begin
                if (req_valid[0])      grant = 3'b001;
                else if (req_valid[1]) grant = 3'b010;
                else if (req_valid[2]) grant = 3'b100;
            end
        endcase
    end

    assign req_ready = rst ? 3'b000 : grant;
    assign transfer  = |req_ready;

    always_comb begin
        grant_idx = 2'd0;
        sel_addr  = req_addr[0 +: ADDR_WIDTH];
        sel_data  = req_data[0 +: DATA_WIDTH];
        if (grant[1]) begin
            grant_idx = 2'd1;
            sel_addr  = req_addr[ADDR_WIDTH +: ADDR_WIDTH];
            sel_data  = req_data[DATA_WIDTH +: DATA_WIDTH];
        end else if (grant[2]) begin
            grant_idx = 2'd2;
            sel_addr  = req_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data  = req_data[2*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 2'd2;
        end else if (transfer) begin
            last_grant <= grant_idx;
        end
    end

    // Writes to x0 still complete the handshake but never raise rf_wen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (transfer) begin
            rf_wen   <= (sel_addr != '0);
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

    assign busy = (|req_valid) | rf_wen;

`ifdef RF_WB_BYPASS_EN
    // Forward the write the register file has not committed yet.
    assign rdata1 = (rf_wen && (raddr1 == rf_waddr) && (raddr1 != '0)) ? rf_wdata : rdata1_in;
    assign rdata2 = (rf_wen && (raddr2 == rf_waddr) && (raddr2 != '0)) ? rf_wdata : rdata2_in;
`else
    logic unused_raddr;
    assign unused_raddr = ^{raddr1, raddr2};
    assign rdata1 = rdata1_in;
    assign rdata2 = rdata2_in;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter: reset, rotation, single write, x0, idle gap, bypass, mid-stream reset.
module tb_rf_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req_valid;
    logic [2:0]    req_ready;
    logic [3*AW-1:0] req_addr;
    logic [3*DW-1:0] req_data;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] raddr1, raddr2;
    logic [DW-1:0] rdata1_in, rdata2_in, rdata1, rdata2;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1_in(rdata1_in), .rdata2_in(rdata2_in),
        .rdata1(rdata1), .rdata2(rdata2),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic drive_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 3'b111;
        drive_req(0, 5'd1, 32'h1); drive_req(1, 5'd2, 32'h2); drive_req(2, 5'd3, 32'h3);
        raddr1 = '0; raddr2 = '0; rdata1_in = '0; rdata2_in = '0;
        @(negedge clk);
        n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
        n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got=%b exp=0", rf_wen); end
        n_checks++; if (rf_waddr !== '0) begin n_fail++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
        n_checks++; if (rf_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_valid got=%b exp=1", busy); end
        req_valid = 3'b000;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_idle got=%b exp=0", busy); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [2:0]    exp_ready [6];
        logic [AW-1:0] exp_addr  [6];
        logic [DW-1:0] exp_data  [6];
        exp_ready = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_addr  = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
        exp_data  = '{32'hA, 32'hB, 32'hC, 32'hA, 32'hB, 32'hC};
        drive_req(0, 5'd1, 32'hA); drive_req(1, 5'd2, 32'hB); drive_req(2, 5'd3, 32'hC);
        req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++; if (req_ready !== exp_ready[i]) begin n_fail++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, req_ready, exp_ready[i]); end
            if (i > 0) begin
                n_checks++;
                if (rf_wen !== 1'b1 || rf_waddr !== exp_addr[i-1] || rf_wdata !== exp_data[i-1]) begin
                    n_fail++;
                    $display("FAIL rr_write[%0d] got wen=%b addr=%0d data=%h exp wen=1 addr=%0d data=%h",
                             i-1, rf_wen, rf_waddr, rf_wdata, exp_addr[i-1], exp_data[i-1]);
                end
            end
            next_cycle();
        end
        req_valid = 3'b000;
        @(negedge clk);
        n_checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hC) begin
            n_fail++; $display("FAIL rr_write[5] got wen=%b addr=%0d data=%h exp wen=1 addr=3 data=c", rf_wen, rf_waddr, rf_wdata);
        end
        next_cycle();
    endtask

    task automatic test_single();
        drive_req(1, 5'd7, 32'hDEADBEEF);
        req_valid = 3'b010;
        @(negedge clk);
        n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL single_ready got=%b exp=010", req_ready); end
        next_cycle();
        req_valid = 3'b000;
        @(negedge clk);
        n_checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_write got wen=%b addr=%0d data=%h exp wen=1 addr=7 data=deadbeef", rf_wen, rf_waddr, rf_wdata);
        end
        next_cycle();
        @(negedge clk);
        n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL single_wen_drop got=%b exp=0", rf_wen); end
        n_checks++;
        if (rf_waddr !== 5'd7 || rf_wdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_hold got addr=%0d data=%h exp addr=7 data=deadbeef", rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_reg_zero();
        drive_req(2, 5'd0, 32'h1234);
        req_valid = 3'b100;
        @(negedge clk);
        n_checks++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL x0_ready got=%b exp=100", req_ready); end
        next_cycle();
        req_valid = 3'b000;
        @(negedge clk);
        n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL x0_wen got=%b exp=0", rf_wen); end
        next_cycle();
    endtask

    task automatic test_idle_gap();
        drive_req(0, 5'd4, 32'h44);
        req_valid = 3'b001;
        @(negedge clk);
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL idle_first_ready got=%b exp=001", req_ready); end
        next_cycle();
        req_valid = 3'b000;
        @(negedge clk);
        n_checks++; if (rf_wen !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL idle_drain got wen=%b busy=%b exp wen=1 busy=1", rf_wen, busy); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            n_checks++; if (busy !== 1'b0 || rf_wen !== 1'b0) begin n_fail++; $display("FAIL idle_busy[%0d] got busy=%b wen=%b exp busy=0 wen=0", i, busy, rf_wen); end
        end
        next_cycle();
        drive_req(0, 5'd8, 32'h80); drive_req(1, 5'd6, 32'h66);
        req_valid = 3'b011;
        @(negedge clk);
        n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL idle_pointer_ready got=%b exp=010", req_ready); end
        next_cycle();
        req_valid = 3'b001;
        @(negedge clk);
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL idle_second_ready got=%b exp=001", req_ready); end
        next_cycle();
        req_valid = 3'b000;
        next_cycle();
    endtask

    task automatic test_bypass();
        logic [DW-1:0] exp1;
`ifdef RF_WB_BYPASS_EN
        exp1 = 32'h55;
`else
        exp1 = 32'h11;
`endif
        drive_req(1, 5'd9, 32'h55);
        req_valid = 3'b010;
        next_cycle();
        req_valid = 3'b000;
        raddr1 = 5'd9; rdata1_in = 32'h11;
        raddr2 = 5'd0; rdata2_in = 32'h22;
        @(negedge clk);
        n_checks++; if (rdata1 !== exp1) begin n_fail++; $display("FAIL bypass_rdata1 got=%h exp=%h", rdata1, exp1); end
        n_checks++; if (rdata2 !== 32'h22) begin n_fail++; $display("FAIL bypass_rdata2_x0 got=%h exp=22", rdata2); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (rdata1 !== 32'h11) begin n_fail++; $display("FAIL bypass_after_commit got=%h exp=11", rdata1); end
        raddr1 = '0;
    endtask

    task automatic test_reset_mid();
        drive_req(0, 5'd5, 32'h5555);
        req_valid = 3'b001;
        @(negedge clk);
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL rmid_ready got=%b exp=001", req_ready); end
        @(posedge clk);
        #2;
        req_valid = 3'b000;
        rst = 1'b1;
        #1;
        n_checks++; if (rf_wen !== 1'b0 || rf_waddr !== '0) begin n_fail++; $display("FAIL rmid_async got wen=%b addr=%0d exp wen=0 addr=0", rf_wen, rf_waddr); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL rmid_no_pulse got=%b exp=0", rf_wen); end
        drive_req(0, 5'd8, 32'h88); drive_req(1, 5'd10, 32'hAA);
        req_valid = 3'b011;
        #1;
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL rmid_next_grant got=%b exp=001", req_ready); end
        next_cycle();
        req_valid = 3'b000;
        @(negedge clk);
        n_checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h88) begin
            n_fail++; $display("FAIL rmid_new_write got wen=%b addr=%0d data=%h exp wen=1 addr=8 data=88", rf_wen, rf_waddr, rf_wdata);
        end
        next_cycle();
    endtask

    initial begin
        req_addr = '0;
        req_data = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_reg_zero();
        test_idle_gap();
        test_bypass();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, default 5, register-file address width.
REQ-002 Parameter: DATA_WIDTH, default 32, register-file data width.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: req_valid  input  3  per-requester write request; bit i = requester i (0 = ALU, 1 = LSU, 2 = CSR).
REQ-006 Port: req_ready  output  3  per-requester grant/accept, combinational, one-hot or zero.
REQ-007 Port: req_addr  input  3*ADDR_WIDTH  destination register; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 Port: req_data  input  3*DATA_WIDTH  write data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port: rf_wen  output  1  registered write enable to the register-file write port.
REQ-010 Port: rf_waddr  output  ADDR_WIDTH  registered write address.
REQ-011 Port: rf_wdata  output  DATA_WIDTH  registered write data.
REQ-012 Port: raddr1, raddr2  input  ADDR_WIDTH each  register-file read addresses, as driven to the file.
REQ-013 Port: rdata1_in, rdata2_in  input  DATA_WIDTH each  raw register-file read data.
REQ-014 Port: rdata1, rdata2  output  DATA_WIDTH each  read data delivered to the core.
REQ-015 Port: busy  output  1  high while any req_valid bit is high or rf_wen is high.

Function
REQ-016 Handshake: a transfer on requester i occurs in a cycle where req_valid[i] and req_ready[i] are both high; the requester keeps req_valid, req_addr and req_data stable until that transfer occurs.
REQ-017 Arbitration: at most one requester is granted per cycle, round-robin; search order starts at (last_grant+1) mod 3 and proceeds upward with wrap-around.
REQ-018 last_grant updates only in cycles with a transfer; cycles with no valid request leave it unchanged.
REQ-019 req_ready[i] depends only on req_valid and last_grant; no request bit is granted unless its valid bit is high.
REQ-020 Write stage: the accepted addr/data is registered; rf_wen/rf_waddr/rf_wdata are valid in the cycle after the transfer (latency 1), so the register file commits on the following edge.
REQ-021 No transfer in a cycle: rf_wen is 0 in the next cycle; rf_waddr and rf_wdata hold their previous values.
REQ-022 Destination register 0: the transfer completes (ready high), but rf_wen is 0 in the next cycle.
REQ-023 Throughput: one write per cycle sustained; with all three requesters continuously valid, grants rotate 0,1,2,0,...
REQ-024 Simultaneous transfer and pending write: the write stage is overwritten every cycle and needs no stall, because the register file accepts one write per cycle.

Reset
REQ-025 While rst is high: rf_wen=0, rf_waddr=0, rf_wdata=0, last_grant=2 (requester 0 has first priority), req_ready=0.
REQ-026 Reset asserted mid-operation: the pending write in the write stage is discarded; no rf_wen pulse occurs after rst falls unless a new transfer takes place.
REQ-027 After rst falls, the first arbitration occurs on the first posedge clk with rst low.

Configuration
REQ-028 Macro RF_WB_BYPASS_EN.
  Defined: rdata1 = rf_wdata when rf_wen=1, raddr1==rf_waddr and raddr1!=0; otherwise rdata1 = rdata1_in. rdata2 is defined the same way with raddr2.
  Undefined: rdata1=rdata1_in and rdata2=rdata2_in (pure pass-through); no comparators are synthesized.
REQ-029 Bypass is purely combinational and never changes arbitration, handshake or write timing.

Verification
REQ-030 rst pulse mid-stream with a pending write to x5 -> rf_wen=0 after reset; x5 not written; next grant goes to requester 0.
REQ-031 All three valid, addrs 1/2/3, data 0xA/0xB/0xC, held for 6 cycles -> ready sequence 001,010,100,001,010,100; rf_waddr sequence 1,2,3,1,2,3 one cycle later.
REQ-032 Single requester 1 writes x7=0xDEADBEEF -> req_ready=010 in cycle 0; rf_wen=1, rf_waddr=7, rf_wdata=0xDEADBEEF in cycle 1; rf_wen=0 in cycle 2.
REQ-033 Requester 2 writes x0=0x1234 -> req_ready[2]=1; rf_wen stays 0.
REQ-034 With RF_WB_BYPASS_EN: x9=0x55 pending, raddr1=9, rdata1_in=0x11 -> rdata1=0x55. Without the macro -> rdata1=0x11. With raddr2=0 -> rdata2=rdata2_in in both builds.
REQ-035 Idle gap: requester 0 is granted, then 3 cycles with no request, then requesters 0 and 1 are both valid -> requester 1 is granted first (pointer held across the idle gap); busy=0 during the idle cycles after the write drains.
